// File: rtl/coherence_pkg.sv
// Shared definitions for the snooping-coherence bus controller.
// Holds the bus codes, the cache line state codes, the field widths of the
// request, instruction and bus words, the controller FSM states and a small
// modulo-3 index helper used by the round-robin arbiter.
package coherence_pkg;

    localparam int NPROC     = 3;
    localparam int IDX_W     = 2;
    localparam int CODE_W    = 2;
    localparam int TAG_W     = 3;
    localparam int VAL_W     = 4;
    localparam int REQ_W     = 1 + TAG_W + VAL_W;          // {op, tag, value}
    localparam int WORD_W    = CODE_W + TAG_W + VAL_W;     // {code, tag, value}
    localparam int INSTR_W   = 1 + IDX_W + TAG_W + VAL_W;  // {op, idx, tag, value}
    localparam int MEM_DEPTH = 8;

    localparam logic [CODE_W-1:0] CODE_READ_MISS  = 2'b01;
    localparam logic [CODE_W-1:0] CODE_WRITE_BACK = 2'b10;
    localparam logic [CODE_W-1:0] CODE_READ_HIT   = 2'b11;

    typedef enum logic [1:0] {
        CS_INVALID  = 2'b00,
        CS_SHARED   = 2'b01,
        CS_MODIFIED = 2'b10
    } cache_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_S1,
        ST_S2,
        ST_S3
    } ctrl_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [TAG_W-1:0]  tag;
        logic [VAL_W-1:0]  value;
    } bus_word_t;

    // (base + off) mod 3, for base in 0..2 and off in 0..3.
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
        logic [IDX_W:0] s;
        s = {1'b0, base} + {1'b0, off};
        if (s >= 3'd3) s = s - 3'd3;
        return s[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Bus bundle between the coherence controller and the processors/caches.
//   req, req_instr  : per-processor requests and packed {op, tag, value} words
//   ack, busy       : transaction handshake back to the processors
//   step            : coherence phase broadcast to every cache
//   instruction     : latched {op, grant_idx, tag, value} broadcast to caches
//   bus_out         : packed outBus words from every cache
//   in_bus          : merged bus word driven to every cache inBus
//   bus_err         : sticky multiple-write-back flag
// The controller uses the slave modport; the processor/cache side uses master.
interface coherence_bus_ctrl_if;
    import coherence_pkg::*;

    logic [NPROC-1:0]        req;
    logic [NPROC*REQ_W-1:0]  req_instr;
    logic [NPROC-1:0]        ack;
    logic                    busy;
    logic [1:0]              step;
    logic [INSTR_W-1:0]      instruction;
    logic [NPROC*WORD_W-1:0] bus_out;
    logic [WORD_W-1:0]       in_bus;
    logic                    bus_err;

    modport master (
        output req, req_instr, bus_out,
        input  ack, busy, step, instruction, in_bus, bus_err
    );

    modport slave (
        input  req, req_instr, bus_out,
        output ack, busy, step, instruction, in_bus, bus_err
    );

endinterface

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter.
//   req   : request vector, bit i = processor i
//   last  : index of the most recent grant
//   grant : one-hot grant, idx : its index, valid : some request was granted
// Search starts at (last + 1) mod 3 and wraps.
module rr_arbiter3 import coherence_pkg::*; (
    input  logic [NPROC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [NPROC-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NPROC; k++) begin
            cand = idx_add(last, IDX_W'(k));
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Snooping-coherence bus controller for three processor/cache pairs.
// Grants one requester at a time (round robin), broadcasts its instruction
// and walks the caches through four coherence phases S0..S3. At the end of
// S0..S2 the caches' outBus words are merged into in_bus; write-backs update
// the 8-entry backing memory, and a read miss left unanswered by the snoop
// phase is served from memory at the end of S2.
//   clock, reset : system clock, synchronous active-high reset
//   bus          : slave side of coherence_bus_ctrl_if
module coherence_bus_ctrl import coherence_pkg::*; #(
    parameter logic [CODE_W-1:0] READ_MISS  = CODE_READ_MISS,
    parameter logic [CODE_W-1:0] READ_HIT   = CODE_READ_HIT,
    parameter logic [CODE_W-1:0] WRITE_BACK = CODE_WRITE_BACK
) (
    input  logic                 clock,
    input  logic                 reset,
    coherence_bus_ctrl_if.slave  bus
);

    ctrl_state_e        state, state_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_idx;
    logic [INSTR_W-1:0] instr_r;
    bus_word_t          in_bus_r;
    logic               bus_err_r;
    logic [VAL_W-1:0]   mem [MEM_DEPTH];

    logic [NPROC-1:0]   arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [REQ_W-1:0]   req_word   [NPROC];
    bus_word_t          cache_word [NPROC];
    bus_word_t          wb_word, gnt_word, merged;
    logic               wb_any;
    logic [1:0]         wb_cnt;
    logic               phase_active, rd_fill;

    logic [1:0]         step;
    logic               busy;
    logic [NPROC-1:0]   ack;

    rr_arbiter3 u_arb (
        .req   (bus.req),
        .last  (last_grant),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        for (int i = 0; i < NPROC; i++) begin
            req_word[i]   = bus.req_instr[i*REQ_W +: REQ_W];
            cache_word[i] = bus.bus_out[i*WORD_W +: WORD_W];
        end
    end

    // Merge: lowest-index write-back wins, then the granted cache's own
    // word unless it is idle, else an idle word.
    always_comb begin
        wb_any   = 1'b0;
        wb_cnt   = '0;
        wb_word  = '0;
        merged   = '{code: READ_HIT, tag: '0, value: '0};
        for (int i = 0; i < NPROC; i++) begin
            if (cache_word[i].code == WRITE_BACK) begin
                if (!wb_any) wb_word = cache_word[i];
                wb_any = 1'b1;
                wb_cnt = wb_cnt + 2'd1;
            end
        end
        gnt_word = cache_word[grant_idx];
        if (wb_any)
            merged = wb_word;
        else if (gnt_word.code != READ_HIT)
            merged = gnt_word;
    end

    assign phase_active = (state == ST_S0) || (state == ST_S1) || (state == ST_S2);
    // in_bus still holds the S1 merge while in S2.
    assign rd_fill = (state == ST_S2) && !wb_any && (in_bus_r.code == READ_MISS);

    always_comb begin
        state_nxt = state;
        step      = 2'b11;
        busy      = 1'b0;
        ack       = '0;
        case (state)
            ST_IDLE: if (arb_valid) state_nxt = ST_S0;
            ST_S0: begin state_nxt = ST_S1;   step = 2'b00; busy = 1'b1; end
            ST_S1: begin state_nxt = ST_S2;   step = 2'b01; busy = 1'b1; end
            ST_S2: begin state_nxt = ST_S3;   step = 2'b10; busy = 1'b1; end
            ST_S3: begin
                state_nxt = ST_IDLE;
                busy      = 1'b1;
                ack       = NPROC'(1) << grant_idx;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 2'd2;
            grant_idx  <= '0;
            instr_r    <= '0;
            in_bus_r   <= '{code: READ_HIT, tag: '0, value: '0};
            bus_err_r  <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && arb_valid) begin
                last_grant <= arb_idx;
                grant_idx  <= arb_idx;
                instr_r    <= {req_word[arb_idx][REQ_W-1], arb_idx,
                               req_word[arb_idx][REQ_W-2:0]};
            end
            if (phase_active) begin
                if (wb_cnt >= 2'd2) bus_err_r <= 1'b1;
                if (wb_any) mem[wb_word.tag] <= wb_word.value;
                if (rd_fill)
                    in_bus_r <= '{code: READ_MISS, tag: in_bus_r.tag,
                                  value: mem[in_bus_r.tag]};
                else
                    in_bus_r <= merged;
            end
        end
    end

    assign bus.step        = step;
    assign bus.busy        = busy;
    assign bus.ack         = ack;
    assign bus.instruction = instr_r;
    assign bus.in_bus      = in_bus_r;
    assign bus.bus_err     = bus_err_r;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed testbench for coherence_bus_ctrl.
module tb_coherence_bus_ctrl;

    localparam logic [8:0]  IDLE_W   = 9'h180;   // {11, 000, 0000}
    localparam logic [26:0] IDLE_BUS = {IDLE_W, IDLE_W, IDLE_W};

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    coherence_bus_ctrl_if bif ();

    coherence_bus_ctrl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bif.req     = '0;
        bif.bus_out = IDLE_BUS;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Request from IDLE; returns observing S0 with req already dropped.
    task automatic start_txn(input logic [2:0] r, input logic [23:0] ri);
        bif.req       = r;
        bif.req_instr = ri;
        tick();
        bif.req = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bif.step !== 2'b11) begin errors++; $display("FAIL reset_step: got %b expected 11", bif.step); end
        checks++; if (bif.instruction !== 10'h000) begin errors++; $display("FAIL reset_instr: got %h expected 000", bif.instruction); end
        checks++; if (bif.in_bus !== 9'h180) begin errors++; $display("FAIL reset_inbus: got %h expected 180", bif.in_bus); end
        checks++; if (bif.ack !== 3'b000) begin errors++; $display("FAIL reset_ack: got %b expected 000", bif.ack); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bif.bus_err); end
    endtask

    task automatic test_single();
        start_txn(3'b001, {16'h0000, 8'h50});
        checks++; if (bif.step !== 2'b00) begin errors++; $display("FAIL single_s0_step: got %b expected 00", bif.step); end
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL single_s0_busy: got %b expected 1", bif.busy); end
        checks++; if (bif.ack !== 3'b000) begin errors++; $display("FAIL single_s0_ack: got %b expected 000", bif.ack); end
        checks++; if (bif.instruction !== 10'h050) begin errors++; $display("FAIL single_instr: got %h expected 050", bif.instruction); end
        bif.req_instr = 24'hFFFFFF;
        tick();
        checks++; if (bif.step !== 2'b01) begin errors++; $display("FAIL single_s1_step: got %b expected 01", bif.step); end
        bif.req = 3'b110;
        tick();
        checks++; if (bif.step !== 2'b10) begin errors++; $display("FAIL single_s2_step: got %b expected 10", bif.step); end
        checks++; if (bif.instruction !== 10'h050) begin errors++; $display("FAIL single_instr_hold: got %h expected 050", bif.instruction); end
        bif.req = '0;
        tick();
        checks++; if (bif.step !== 2'b11) begin errors++; $display("FAIL single_s3_step: got %b expected 11", bif.step); end
        checks++; if (bif.ack !== 3'b001) begin errors++; $display("FAIL single_s3_ack: got %b expected 001", bif.ack); end
        checks++; if (bif.busy !== 1'b1) begin errors++; $display("FAIL single_s3_busy: got %b expected 1", bif.busy); end
        checks++; if (bif.in_bus !== 9'h180) begin errors++; $display("FAIL single_inbus: got %h expected 180", bif.in_bus); end
        tick();
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.ack !== 3'b000) begin errors++; $display("FAIL single_idle_ack: got %b expected 000", bif.ack); end
    endtask

    task automatic test_round_robin();
        logic [9:0] exp_i [4];
        logic [2:0] exp_a [4];
        exp_i = '{10'h011, 10'h0A2, 10'h133, 10'h011};
        exp_a = '{3'b001, 3'b010, 3'b100, 3'b001};
        do_reset();
        bif.req_instr = {8'h33, 8'h22, 8'h11};
        bif.req       = 3'b111;
        for (int g = 0; g < 4; g++) begin
            tick();
            checks++; if (bif.step !== 2'b00) begin errors++; $display("FAIL rr_grant_edge%0d: got step %b expected 00", g, bif.step); end
            checks++; if (bif.instruction !== exp_i[g]) begin errors++; $display("FAIL rr_instr%0d: got %h expected %h", g, bif.instruction, exp_i[g]); end
            tick();
            tick();
            tick();
            checks++; if (bif.ack !== exp_a[g]) begin errors++; $display("FAIL rr_ack%0d: got %b expected %b", g, bif.ack, exp_a[g]); end
            if (g == 3) bif.req = '0;
            tick();
            checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL rr_idle%0d: got busy %b expected 0", g, bif.busy); end
        end
    endtask

    task automatic test_snoop_write_back();
        do_reset();
        start_txn(3'b001, {16'h0000, 8'h20});
        tick();
        checks++; if (bif.in_bus !== 9'h180) begin errors++; $display("FAIL snoop_s0_merge: got %h expected 180", bif.in_bus); end
        bif.bus_out = {IDLE_W, IDLE_W, 9'h0A0};
        tick();
        checks++; if (bif.in_bus !== 9'h0A0) begin errors++; $display("FAIL snoop_s1_merge: got %h expected 0a0", bif.in_bus); end
        bif.bus_out = {IDLE_W, 9'h127, IDLE_W};
        tick();
        checks++; if (bif.in_bus !== 9'h127) begin errors++; $display("FAIL snoop_s3_inbus: got %h expected 127", bif.in_bus); end
        bif.bus_out = IDLE_BUS;
        tick();
        checks++; if (bif.in_bus !== 9'h127) begin errors++; $display("FAIL snoop_idle_hold: got %h expected 127", bif.in_bus); end
        checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL snoop_no_err: got %b expected 0", bif.bus_err); end
        start_txn(3'b001, {16'h0000, 8'h20});
        tick();
        bif.bus_out = {IDLE_W, IDLE_W, 9'h0A0};
        tick();
        bif.bus_out = IDLE_BUS;
        tick();
        checks++; if (bif.in_bus !== 9'h0A7) begin errors++; $display("FAIL snoop_mem_readback: got %h expected 0a7", bif.in_bus); end
        tick();
    endtask

    task automatic test_read_miss_mem();
        do_reset();
        start_txn(3'b001, {16'h0000, 8'h20});
        bif.bus_out = {IDLE_W, 9'h129, IDLE_W};
        tick();
        checks++; if (bif.in_bus !== 9'h129) begin errors++; $display("FAIL rm_wb_merge: got %h expected 129", bif.in_bus); end
        bif.bus_out = IDLE_BUS;
        tick();
        tick();
        checks++; if (bif.in_bus !== 9'h180) begin errors++; $display("FAIL rm_idle_merge: got %h expected 180", bif.in_bus); end
        tick();
        start_txn(3'b001, {16'h0000, 8'h20});
        tick();
        bif.bus_out = {IDLE_W, IDLE_W, 9'h0A0};
        tick();
        bif.bus_out = IDLE_BUS;
        tick();
        checks++; if (bif.in_bus !== 9'h0A9) begin errors++; $display("FAIL rm_fill: got %h expected 0a9", bif.in_bus); end
        tick();
    endtask

    task automatic test_bus_err();
        do_reset();
        start_txn(3'b001, {16'h0000, 8'h30});
        bif.bus_out = {9'h13C, IDLE_W, 9'h135};
        tick();
        checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bif.bus_err); end
        checks++; if (bif.in_bus !== 9'h135) begin errors++; $display("FAIL err_lowest_wins: got %h expected 135", bif.in_bus); end
        bif.bus_out = IDLE_BUS;
        tick();
        tick();
        tick();
        checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky_idle: got %b expected 1", bif.bus_err); end
        start_txn(3'b001, {16'h0000, 8'h30});
        tick();
        bif.bus_out = {IDLE_W, IDLE_W, 9'h0B0};
        tick();
        bif.bus_out = IDLE_BUS;
        tick();
        checks++; if (bif.in_bus !== 9'h0B5) begin errors++; $display("FAIL err_mem_cache0: got %h expected 0b5", bif.in_bus); end
        checks++; if (bif.bus_err !== 1'b1) begin errors++; $display("FAIL err_sticky_txn: got %b expected 1", bif.bus_err); end
        tick();
        do_reset();
        checks++; if (bif.bus_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bif.bus_err); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start_txn(3'b001, {16'h0000, 8'h40});
        tick();
        tick();
        checks++; if (bif.step !== 2'b10) begin errors++; $display("FAIL mid_in_s2: got %b expected 10", bif.step); end
        bif.bus_out = {IDLE_W, 9'h14F, IDLE_W};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.bus_out = IDLE_BUS;
        checks++; if (bif.step !== 2'b11) begin errors++; $display("FAIL mid_step: got %b expected 11", bif.step); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bif.busy); end
        checks++; if (bif.in_bus !== 9'h180) begin errors++; $display("FAIL mid_inbus: got %h expected 180", bif.in_bus); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (bif.ack !== 3'b000) begin errors++; $display("FAIL mid_no_ack%0d: got %b expected 000", c, bif.ack); end
            tick();
        end
        start_txn(3'b001, {16'h0000, 8'h40});
        tick();
        bif.bus_out = {IDLE_W, IDLE_W, 9'h0C0};
        tick();
        bif.bus_out = IDLE_BUS;
        tick();
        checks++; if (bif.in_bus !== 9'h0C0) begin errors++; $display("FAIL mid_mem_untouched: got %h expected 0c0", bif.in_bus); end
        checks++; if (bif.ack !== 3'b001) begin errors++; $display("FAIL mid_next_ack: got %b expected 001", bif.ack); end
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        bif.req       = '0;
        bif.req_instr = '0;
        bif.bus_out   = IDLE_BUS;
        test_reset();
        test_single();
        test_round_robin();
        test_snoop_write_back();
        test_read_miss_mem();
        test_bus_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
